// File: rtl/regfile_dump.sv
// regfile_dump: walks the register-file read port over [FIRST_REG, LAST_REG] and streams
// each word out as an addr/data beat with valid/ready, accumulating an XOR checksum.
module regfile_dump #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_raddr,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_xsum
);
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, OUT = 2'd2, DONE = 2'd3;
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_REG);
  logic [1:0] state;
  logic [ADDR_W-1:0] cnt;
  // valid/busy/done are pure decodes of the state register, so no input reaches an output
  assign o_raddr = cnt;
  assign o_valid = state == OUT;
  assign o_busy  = state != IDLE;
  assign o_done  = state == DONE;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      cnt    <= FIRST;
      o_addr <= '0;
      o_data <= '0;
      o_last <= 1'b0;
      o_xsum <= '0;
    end else if (i_abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          cnt    <= FIRST;
          o_xsum <= '0;
          state  <= RD;
        end
        RD: begin
          o_data <= i_rdata;
          o_addr <= cnt;
          o_last <= cnt == LAST;
          state  <= OUT;
        end
        OUT: if (i_ready) begin
          o_xsum <= o_xsum ^ o_data;
          if (o_last) state <= DONE;
          else begin
            cnt   <= cnt + 1'b1;
            state <= RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: table-driven dump scenarios with a beat scoreboard, plus hand-written
// sequences for reset, start/abort corner cases and a single-register range.
module tb_regfile_dump;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, start, abort, ready, start1;
  logic [4:0] raddr, addr, raddr1, addr1;
  logic [31:0] rdata, data, xsum, rdata1, data1, xsum1;
  logic valid, last, busy, done, valid1, last1, busy1, done1;
  logic [31:0] mem [32];
  assign rdata  = mem[raddr];
  assign rdata1 = raddr1 == 5'd7 ? 32'hDEADBEEF : 32'h0;

  regfile_dump dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .o_raddr(raddr), .i_rdata(rdata), .o_valid(valid), .i_ready(ready),
    .o_addr(addr), .o_data(data), .o_last(last), .o_busy(busy),
    .o_done(done), .o_xsum(xsum)
  );

  regfile_dump #(.FIRST_REG(7), .LAST_REG(7)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_abort(abort),
    .o_raddr(raddr1), .i_rdata(rdata1), .o_valid(valid1), .i_ready(ready),
    .o_addr(addr1), .o_data(data1), .o_last(last1), .o_busy(busy1),
    .o_done(done1), .o_xsum(xsum1)
  );

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {logic [4:0] addr; logic [31:0] data; logic last;} beat_t;
  beat_t sb[$];
  beat_t cur;
  logic hold = 1'b0;
  logic [4:0] h_addr;
  logic [31:0] h_data;

  // Beats are judged at the falling edge, i.e. with the values the next rising edge will see
  always @(negedge clk) begin
    if (rst_n && hold) begin
      chk("hold_valid", valid, 1);
      chk("hold_addr", addr, h_addr);
      chk("hold_data", data, h_data);
    end
    if (rst_n && valid && ready && !abort) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL extra_beat: got addr %0d, expected no beat", addr);
      end else begin
        cur = sb.pop_front();
        chk("beat_addr", addr, cur.addr);
        chk("beat_data", data, cur.data);
        chk("beat_last", last, cur.last);
      end
    end
    hold   <= rst_n && valid && !ready && !abort;
    h_addr <= addr;
    h_data <= data;
  end

  task automatic chk_reset_vals();
    chk("rst_raddr", raddr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    chk("rst_last", last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_xsum", xsum, 0);
  endtask

  // mode: 0 ready high, 1 random; kind: 0 none, 1 abort at beat cut, 2 reset at beat cut
  typedef struct {int mode; int kind; int cut; int restart; logic [31:0] xsum; int ndone; int done_n;} vec_t;
  vec_t vt [6];

  task automatic run(input vec_t v);
    int n, ndone, done_at, nb;
    nb = v.kind == 0 ? 32 : v.cut;
    for (int i = 0; i < nb; i++) sb.push_back('{5'(i), 32'(i + 1), 1'(i == 31)});
    start = 1;
    @(posedge clk); #1;
    start = 0;
    n = 0; ndone = 0; done_at = -1;
    while (busy && n < 4000) begin
      ready = v.mode != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      if (n == v.restart) start = 1;
      if (v.kind == 1 && valid && addr == 5'(v.cut)) begin
        ready = 1;
        abort = 1;
      end
      if (v.kind == 2 && valid && addr == 5'(v.cut)) begin
        #1 rst_n = 0;
        #1 chk_reset_vals();
        #1 rst_n = 1;
      end
      @(posedge clk); #1;
      n++;
      start = 0;
      abort = 0;
      if (done) begin
        ndone++;
        done_at = n;
      end
    end
    chk("timeout", n < 4000, 1);
    if (v.done_n >= 0) begin
      chk("done_edge", done_at, v.done_n);
      chk("idle_edge", n, v.done_n + 1);
    end
    chk("done_count", ndone, v.ndone);
    chk("end_valid", valid, 0);
    chk("xsum", xsum, v.xsum);
    chk("beats_left", sb.size(), 0);
    sb.delete();
    ready = 1;
  endtask

  initial begin
    rst_n = 0; start = 0; start1 = 0; abort = 0; ready = 1;
    for (int i = 0; i < 32; i++) mem[i] = 32'(i + 1);
    vt[0] = '{0, 0, -1, -1, 32'h20, 1, 64};
    vt[1] = '{1, 0, -1, -1, 32'h20, 1, -1};
    vt[2] = '{0, 1, 5, -1, 32'h1, 0, -1};
    vt[3] = '{0, 0, -1, -1, 32'h20, 1, 64};
    vt[4] = '{0, 0, -1, 10, 32'h20, 1, 64};
    vt[5] = '{0, 2, 10, -1, 32'h0, 0, -1};
    #12;
    chk_reset_vals();
    chk("rst_raddr1", raddr1, 7);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 0;
    chk("start_abort_busy", busy, 0);
    @(posedge clk); #1;
    chk("start_abort_busy2", busy, 0);
    for (int t = 0; t < 6; t++) run(vt[t]);
    @(posedge clk); #1;
    chk("post_reset_busy", busy, 0);
    start1 = 1;
    @(posedge clk); #1;
    start1 = 0;
    chk("single_busy", busy1, 1);
    chk("single_rd_valid", valid1, 0);
    @(posedge clk); #1;
    chk("single_valid", valid1, 1);
    chk("single_last", last1, 1);
    chk("single_addr", addr1, 7);
    chk("single_data", data1, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("single_done", done1, 1);
    chk("single_valid_off", valid1, 0);
    chk("single_xsum", xsum1, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("single_idle", busy1, 0);
    chk("single_done_off", done1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
